high_score_collector: RTL and testbench

//  Downstream of the engine systolic array. Watches the per-PE high-score flags and cell scores each

---
 rtl/high_score_collector.sv | 177 +++++++++++++++++
 tb/tb_high_score_collector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/high_score_collector.sv
// Serialises flagged PE scores into {pe, column, score} hit records behind a FIFO; first record
// valid two cycles after capture; scan holds while the FIFO is full, stall_req_out asks the array to wait.

module hsc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_rdy,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop_rdy)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CNT_W'(push_vld) - CNT_W'(pop_rdy);
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module high_score_collector #(
  parameter int NUM_PES    = 64,
  parameter int WIDTH      = 10,
  parameter int COL_WIDTH  = 25,
  parameter int FIFO_DEPTH = 16,
  parameter int PE_IDX_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       align_start_in,
  input  logic [NUM_PES*WIDTH-1:0]   V_in,
  input  logic [NUM_PES-1:0]         high_score_in,
  output logic                       stall_req_out,
  output logic [PE_IDX_W-1:0]        hit_pe_out,
  output logic [COL_WIDTH-1:0]       hit_col_out,
  output logic [WIDTH-1:0]           hit_score_out,
  output logic                       hit_valid_out,
  input  logic                       hit_rdy_in,
  output logic [15:0]                hit_count_out,
  output logic                       overflow_out
);
  localparam int REC_W = PE_IDX_W + COL_WIDTH + WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                     state, state_nxt;
  logic [COL_WIDTH-1:0]       col, col_cur, cap_col;
  logic [NUM_PES-1:0]         mask, mask_nxt;
  logic [NUM_PES*WIDTH-1:0]   scores;
  logic                       align_go, capture, load, ovf_set;
  logic [PE_IDX_W-1:0]        sel_idx;
  logic                       sel_found;
  logic [WIDTH-1:0]           sel_score;
  logic                       push, pop, fifo_full, stall_req_nxt;
  logic [CNT_W-1:0]           fifo_cnt, cnt_nxt;
  logic [REC_W-1:0]           head_dat;

  assign align_go = align_start_in & ~stall;
  assign capture  = ~stall & (|high_score_in);
  assign col_cur  = align_go ? '0 : col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col <= '0;
    else if (!stall) col <= col_cur + COL_WIDTH'(1);
  end

  // Lowest set bit of the pending mask picks the next PE to emit.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_PES; i++) begin
      if (mask[i] && !sel_found) begin
        sel_idx   = PE_IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign sel_score = scores[sel_idx*WIDTH +: WIDTH];
  assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push      = (state == SCAN) & ~fifo_full;
  assign pop       = hit_valid_out & hit_rdy_in;
  assign cnt_nxt   = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    load      = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          load      = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        // A second vector while still scanning has nowhere to go.
        if (capture) ovf_set = 1'b1;
        if (push) begin
          mask_nxt[sel_idx] = 1'b0;
          if (mask_nxt == '0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_req_nxt = ((state == SCAN) && (state_nxt == IDLE)) ||
                         (cnt_nxt >= CNT_W'(FIFO_DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mask          <= '0;
      scores        <= '0;
      cap_col       <= '0;
      overflow_out  <= 1'b0;
      stall_req_out <= 1'b0;
      hit_count_out <= '0;
    end else begin
      state         <= state_nxt;
      stall_req_out <= stall_req_nxt;
      if (ovf_set) overflow_out <= 1'b1;
      if (load) begin
        mask    <= high_score_in;
        scores  <= V_in;
        cap_col <= col_cur;
      end else begin
        mask    <= mask_nxt;
      end
      if (align_go) hit_count_out <= push ? 16'd1 : 16'd0;
      else if (push && hit_count_out != 16'hFFFF) hit_count_out <= hit_count_out + 16'd1;
    end
  end

  hsc_fifo #(
    .W     (REC_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push),
    .push_dat ({sel_idx, cap_col, sel_score}),
    .pop_rdy  (pop),
    .head_dat (head_dat),
    .cnt      (fifo_cnt)
  );

  assign hit_valid_out = (fifo_cnt != '0);
  assign {hit_pe_out, hit_col_out, hit_score_out} = hit_valid_out ? head_dat : '0;
endmodule

// File: tb/tb_high_score_collector.sv
// Directed bench for high_score_collector; column width is narrowed so the wrap case is reachable.
module tb_high_score_collector;
  localparam int NP = 64;
  localparam int W  = 10;
  localparam int CW = 10;
  localparam int FD = 16;
  localparam int PW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall;
  logic            align_start_in;
  logic [NP*W-1:0] V_in;
  logic [NP-1:0]   high_score_in;
  logic            stall_req_out;
  logic [PW-1:0]   hit_pe_out;
  logic [CW-1:0]   hit_col_out;
  logic [W-1:0]    hit_score_out;
  logic            hit_valid_out;
  logic            hit_rdy_in;
  logic [15:0]     hit_count_out;
  logic            overflow_out;

  always #5 clk = ~clk;

  high_score_collector #(
    .NUM_PES(NP), .WIDTH(W), .COL_WIDTH(CW), .FIFO_DEPTH(FD), .PE_IDX_W(PW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .align_start_in (align_start_in),
    .V_in           (V_in),
    .high_score_in  (high_score_in),
    .stall_req_out  (stall_req_out),
    .hit_pe_out     (hit_pe_out),
    .hit_col_out    (hit_col_out),
    .hit_score_out  (hit_score_out),
    .hit_valid_out  (hit_valid_out),
    .hit_rdy_in     (hit_rdy_in),
    .hit_count_out  (hit_count_out),
    .overflow_out   (overflow_out)
  );

  typedef struct packed {
    logic [PW-1:0] pe;
    logic [CW-1:0] col;
    logic [W-1:0]  score;
  } rec_t;

  rec_t recs[$];
  rec_t mon_r;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_hi = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Records are taken at the falling edge, i.e. one half-cycle before the pop.
  always @(negedge clk) begin
    if (rst_n && hit_valid_out && hit_rdy_in) begin
      mon_r.pe    = hit_pe_out;
      mon_r.col   = hit_col_out;
      mon_r.score = hit_score_out;
      recs.push_back(mon_r);
    end
    if (stall_req_out) stall_hi++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_v(input int pe, input int val);
    V_in[pe*W +: W] = W'(val);
  endtask

  task automatic check_rec(input string tag, input int i, input int pe, input int col, input int score);
    if (recs.size() > i) begin
      check({tag, "_pe"},    64'(recs[i].pe),    64'(pe));
      check({tag, "_col"},   64'(recs[i].col),   64'(col));
      check({tag, "_score"}, 64'(recs[i].score), 64'(score));
    end else begin
      check({tag, "_present"}, 64'(recs.size()), 64'(i + 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall_req"}, 64'(stall_req_out), 64'd0);
    check({tag, "_pe"},        64'(hit_pe_out),    64'd0);
    check({tag, "_col"},       64'(hit_col_out),   64'd0);
    check({tag, "_score"},     64'(hit_score_out), 64'd0);
    check({tag, "_valid"},     64'(hit_valid_out), 64'd0);
    check({tag, "_count"},     64'(hit_count_out), 64'd0);
    check({tag, "_overflow"},  64'(overflow_out),  64'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; align_start_in = 1'b0;
    V_in = '0; high_score_in = '0; hit_rdy_in = 1'b0;
    step(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step(1);

    // T2: two flagged PEs at column 4.
    recs.delete(); hit_rdy_in = 1'b1;
    align_start_in = 1'b1; step(1);
    align_start_in = 1'b0; step(3);
    high_score_in = 64'h5; set_v(0, 7); set_v(2, 9);
    stall_hi = 0;
    step(1);
    check("t2_valid_after_capture", 64'(hit_valid_out), 64'd0);
    high_score_in = '0;
    step(1);
    check("t2_valid_first", 64'(hit_valid_out), 64'd1);
    step(6);
    check("t2_nrec", 64'(recs.size()), 64'd2);
    check_rec("t2_r0", 0, 0, 4, 7);
    check_rec("t2_r1", 1, 2, 4, 9);
    check("t2_hit_count", 64'(hit_count_out), 64'd2);
    check("t2_stall_cycles", 64'(stall_hi), 64'd1);
    check("t2_valid_end", 64'(hit_valid_out), 64'd0);

    // T3: all flags with consumer blocked, then drain.
    recs.delete(); hit_rdy_in = 1'b0;
    align_start_in = 1'b1; high_score_in = '1;
    for (int i = 0; i < NP; i++) set_v(i, i + 100);
    step(1);
    align_start_in = 1'b0; high_score_in = '0;
    step(20);
    check("t3_hold_count", 64'(hit_count_out), 64'd16);
    check("t3_hold_stall", 64'(stall_req_out), 64'd1);
    check("t3_hold_valid", 64'(hit_valid_out), 64'd1);
    check("t3_hold_head_pe", 64'(hit_pe_out), 64'd0);
    check("t3_hold_head_score", 64'(hit_score_out), 64'd100);
    stall_hi = 0;
    step(4);
    check("t3_hold_stall_cycles", 64'(stall_hi), 64'd4);
    hit_rdy_in = 1'b1;
    step(90);
    check("t3_nrec", 64'(recs.size()), 64'd64);
    for (int i = 0; i < NP; i++) check_rec($sformatf("t3_r%0d", i), i, i, 0, i + 100);
    check("t3_stall_end", 64'(stall_req_out), 64'd0);
    check("t3_hit_count", 64'(hit_count_out), 64'd64);
    check("t3_overflow", 64'(overflow_out), 64'd0);

    // T4: back-to-back flagged vectors; column is 115 after T3.
    recs.delete(); V_in = '0; set_v(3, 33); set_v(7, 77);
    high_score_in = 64'h8; step(1);
    high_score_in = 64'h80; step(1);
    high_score_in = '0; step(8);
    check("t4_overflow", 64'(overflow_out), 64'd1);
    check("t4_nrec", 64'(recs.size()), 64'd1);
    check_rec("t4_r0", 0, 3, 115, 33);
    check("t4_hit_count", 64'(hit_count_out), 64'd65);

    // T5: stalled inputs are ignored.
    recs.delete(); V_in = '0; set_v(1, 11); set_v(5, 55); set_v(9, 99);
    align_start_in = 1'b1; step(1);
    align_start_in = 1'b0; high_score_in = 64'h2; step(1);
    high_score_in = '0; step(5);
    stall = 1'b1; align_start_in = 1'b1; high_score_in = 64'h20;
    step(3);
    check("t5_stall_count", 64'(hit_count_out), 64'd1);
    check("t5_stall_valid", 64'(hit_valid_out), 64'd0);
    stall = 1'b0; align_start_in = 1'b0; high_score_in = 64'h200;
    step(1);
    high_score_in = '0; step(6);
    check("t5_nrec", 64'(recs.size()), 64'd2);
    check_rec("t5_r0", 0, 1, 1, 11);
    check_rec("t5_r1", 1, 9, 7, 99);
    check("t5_hit_count", 64'(hit_count_out), 64'd2);

    // T6: column wrap.
    recs.delete(); V_in = '0; set_v(4, 44); set_v(6, 66);
    align_start_in = 1'b1; step(1);
    align_start_in = 1'b0; step(1022);
    high_score_in = 64'h10; step(1);
    high_score_in = '0; stall = 1'b1; step(1);
    stall = 1'b0; high_score_in = 64'h40; step(1);
    high_score_in = '0; step(6);
    check("t6_nrec", 64'(recs.size()), 64'd2);
    check_rec("t6_r0", 0, 4, 1023, 44);
    check_rec("t6_r1", 1, 6, 0, 66);

    // T1: reset while scanning with three records buffered.
    recs.delete(); hit_rdy_in = 1'b0; V_in = '0;
    for (int i = 0; i < 8; i++) set_v(i, i + 1);
    high_score_in = 64'hFF; step(1);
    high_score_in = '0; step(3);
    check("t1_pre_valid", 64'(hit_valid_out), 64'd1);
    check("t1_pre_score", 64'(hit_score_out), 64'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t1_async");
    step(2);
    rst_n = 1'b1; hit_rdy_in = 1'b1;
    step(20);
    check("t1_nrec", 64'(recs.size()), 64'd0);
    check_idle_outputs("t1_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
